arq_tx_sequencer: RTL and testbench

//  Stop-and-wait ARQ sequencer for the TX datapath. Pops one frame at a time from the TX FIFO and

---
 rtl/arq_pkg.sv | 15 +
 rtl/arq_timeout_timer.sv | 37 +++
 rtl/arq_tx_sequencer.sv | 158 +++++++++++++++
 tb/tb_arq_tx_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arq_pkg.sv
// Shared ARQ types and constants for the TX sequencer and the receiver side.
package arq_pkg;

  typedef enum logic [1:0] {
    ARQ_IDLE,
    ARQ_SEND,
    ARQ_WAIT
  } arq_state_t;

  localparam logic ARQ_ACK  = 1'b0;
  localparam logic ARQ_NACK = 1'b1;

  localparam int ARQ_STAT_W = 16;

endpackage

// File: rtl/arq_timeout_timer.sv
// Saturating WAIT_ACK timer: flags expiry when the count reaches TIMEOUT-1.
module arq_timeout_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q, count_d;

  // Holds at LAST instead of wrapping, so a late exit never sees a stale low count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && (count_q != LAST)) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/arq_tx_sequencer.sv
// Stop-and-wait ARQ sequencer between the TX FIFO and the link/ack interface.
// Optional build macro ARQ_STATS_EN adds 16-bit saturating frame/retx/drop counters.
module arq_tx_sequencer
  import arq_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int TIMEOUT    = 16,
  parameter int MAX_RETRY  = 3,
  localparam int CW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_pop,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_seq,
  input  logic                  rx_ack_valid,
  input  logic                  rx_ack_nack,
  input  logic                  rx_ack_seq,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_drop,
  output logic [CW-1:0]         retry_cnt
`ifdef ARQ_STATS_EN
  ,
  output logic [ARQ_STAT_W-1:0] stat_frames,
  output logic [ARQ_STAT_W-1:0] stat_retx,
  output logic [ARQ_STAT_W-1:0] stat_drops
`endif
);

  localparam logic [CW-1:0] RETRY_MAX = CW'(MAX_RETRY);

  arq_state_t            state_q, state_d;
  logic                  seq_q, seq_d;
  logic [CW-1:0]         retry_q, retry_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic                  done_q, done_d;
  logic                  drop_q, drop_d;
  logic                  pop_req;
  logic                  retx;
  logic                  resp_match;
  logic                  expired;

  arq_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != ARQ_WAIT),
    .run     (state_q == ARQ_WAIT),
    .expired (expired)
  );

  assign resp_match = rx_ack_valid && (rx_ack_seq == seq_q);

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    retry_d = retry_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    pop_req = 1'b0;
    retx    = 1'b0;
    unique case (state_q)
      ARQ_IDLE: begin
        if (enable && !fifo_empty) begin
          pop_req = 1'b1;
          frame_d = fifo_rdata;
          retry_d = '0;
          state_d = ARQ_SEND;
        end
      end
      ARQ_SEND: begin
        if (tx_ready) begin
          state_d = ARQ_WAIT;
        end
      end
      ARQ_WAIT: begin
        // A matching ACK beats a NACK or timeout landing on the same cycle.
        if (resp_match && (rx_ack_nack == ARQ_ACK)) begin
          done_d  = 1'b1;
          seq_d   = ~seq_q;
          state_d = ARQ_IDLE;
        end else if ((resp_match && (rx_ack_nack == ARQ_NACK)) || expired) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + CW'(1);
            retx    = 1'b1;
            state_d = ARQ_SEND;
          end else begin
            drop_d  = 1'b1;
            seq_d   = ~seq_q;
            state_d = ARQ_IDLE;
          end
        end
      end
      default: state_d = ARQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARQ_IDLE;
      seq_q   <= 1'b0;
      retry_q <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      retry_q <= retry_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // Never advance the FIFO while reset is held: the word would be lost.
  assign fifo_pop   = pop_req && rst_n;
  assign tx_valid   = (state_q == ARQ_SEND);
  assign tx_data    = frame_q;
  assign tx_seq     = seq_q;
  assign busy       = (state_q != ARQ_IDLE);
  assign frame_done = done_q;
  assign frame_drop = drop_q;
  assign retry_cnt  = retry_q;

`ifdef ARQ_STATS_EN
  logic [ARQ_STAT_W-1:0] frames_q, retx_q, drops_q;

  function automatic logic [ARQ_STAT_W-1:0] sat_inc(input logic [ARQ_STAT_W-1:0] v);
    return (v == '1) ? v : v + ARQ_STAT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frames_q <= '0;
      retx_q   <= '0;
      drops_q  <= '0;
    end else begin
      if (done_d) frames_q <= sat_inc(frames_q);
      if (retx)   retx_q   <= sat_inc(retx_q);
      if (drop_d) drops_q  <= sat_inc(drops_q);
    end
  end

  assign stat_frames = frames_q;
  assign stat_retx   = retx_q;
  assign stat_drops  = drops_q;
`endif

endmodule

// File: tb/tb_arq_tx_sequencer.sv
// Directed and randomized bench for arq_tx_sequencer against a per-frame transaction model.
module tb_arq_tx_sequencer;
  import arq_pkg::*;

  localparam int DW = 4;
  localparam int TO = 16;
  localparam int MR = 3;
  localparam int K_ACK = 0, K_NACK = 1, K_NONE = 2;

  logic          clk = 1'b0;
  logic          rst_n, enable, fifo_empty, fifo_pop;
  logic [DW-1:0] fifo_rdata, tx_data;
  logic          tx_valid, tx_ready, tx_seq;
  logic          rx_ack_valid, rx_ack_nack, rx_ack_seq;
  logic          busy, frame_done, frame_drop;
  logic [1:0]    retry_cnt;
`ifdef ARQ_STATS_EN
  logic [15:0]   stat_frames, stat_retx, stat_drops;
`endif

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int pop_empty = 0;
  logic [DW-1:0] fq[$];
  bit model_seq;

  // Per-attempt response plan for the frame under test.
  int pk[MR+1];
  int pd[MR+1];
  int ps[MR+1];
  bit pst[MR+1];

  always #5 clk = ~clk;

  arq_tx_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_rdata   (fifo_rdata),
    .fifo_pop     (fifo_pop),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_seq       (tx_seq),
    .rx_ack_valid (rx_ack_valid),
    .rx_ack_nack  (rx_ack_nack),
    .rx_ack_seq   (rx_ack_seq),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_drop   (frame_drop),
    .retry_cnt    (retry_cnt)
`ifdef ARQ_STATS_EN
    ,
    .stat_frames  (stat_frames),
    .stat_retx    (stat_retx),
    .stat_drops   (stat_drops)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit p;
    @(negedge clk);
    p = fifo_pop;
    @(posedge clk);
    #1;
    if (p) begin
      pops++;
      if (fq.size() == 0) pop_empty++;
      else void'(fq.pop_front());
    end
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() > 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
    fifo_rdata = fq[0];
  endtask

  task automatic set_plan(input int a, input int k, input int d, input int s, input bit st);
    pk[a] = k; pd[a] = d; ps[a] = s; pst[a] = st;
  endtask

  // One frame: pop, then per attempt transmit, wait, respond, and predict the outcome.
  task automatic run_frame(input logic [DW-1:0] data, input bit do_push, input string tag);
    int a;
    int d;
    int pops0;
    bit fin;
    pops0 = pops;
    if (do_push) push(data);
    step();
    a = 0;
    fin = 0;
    while (!fin) begin
      chk({tag, "/tx_valid"}, tx_valid, 1);
      chk({tag, "/tx_data"}, tx_data, data);
      chk({tag, "/tx_seq"}, tx_seq, model_seq);
      chk({tag, "/retry_cnt"}, retry_cnt, a);
      tx_ready = 1'b0;
      for (int s = 0; s < ps[a]; s++) begin
        step();
        chk({tag, "/stall_hold"}, {tx_valid, tx_data}, {1'b1, data});
      end
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      d = (pk[a] == K_NONE) ? TO : pd[a];
      for (int k = 1; k < d; k++) begin
        if (pst[a] && k == 1) begin
          rx_ack_valid = 1'b1;
          rx_ack_nack  = 1'($urandom_range(0, 1));
          rx_ack_seq   = ~model_seq;
        end
        step();
        rx_ack_valid = 1'b0;
      end
      chk({tag, "/waiting"}, {busy, tx_valid}, 2'b10);
      if (pk[a] != K_NONE) begin
        rx_ack_valid = 1'b1;
        rx_ack_nack  = (pk[a] == K_NACK) ? ARQ_NACK : ARQ_ACK;
        rx_ack_seq   = model_seq;
      end
      step();
      rx_ack_valid = 1'b0;
      if (pk[a] == K_ACK) begin
        chk({tag, "/done"}, {frame_done, frame_drop, busy}, 3'b100);
        model_seq = ~model_seq;
        fin = 1;
      end else if (a < MR) begin
        chk({tag, "/retx"}, {tx_valid, frame_done, frame_drop}, 3'b100);
        a++;
      end else begin
        chk({tag, "/drop"}, {frame_done, frame_drop, busy}, 3'b010);
        model_seq = ~model_seq;
        fin = 1;
      end
    end
    chk({tag, "/one_pop"}, pops - pops0, 1);
  endtask

  initial begin
`ifdef ARQ_STATS_EN
    int r0;
`endif
    int pops0;
    rst_n = 1'b0; enable = 1'b1; fifo_empty = 1'b1; fifo_rdata = '0;
    tx_ready = 1'b0; rx_ack_valid = 1'b0; rx_ack_nack = 1'b0; rx_ack_seq = 1'b0;
    model_seq = 1'b0;
    step();
    step();
    chk("reset_state", {busy, tx_valid, tx_seq, retry_cnt, frame_done, frame_drop, fifo_pop}, 8'h00);
    rst_n = 1'b1;
    step();

    // Scenario 1: ACK two cycles after handshake, then a second frame on seq 1.
    for (int a = 0; a <= MR; a++) set_plan(a, K_ACK, 2, 0, 0);
    run_frame(4'h5, 1, "s1a");
    run_frame(4'h6, 1, "s1b");

    // Scenario 2: NACK, NACK, ACK.
`ifdef ARQ_STATS_EN
    r0 = int'(stat_retx);
`endif
    set_plan(0, K_NACK, 3, 0, 0);
    set_plan(1, K_NACK, 1, 0, 0);
    set_plan(2, K_ACK, 4, 0, 0);
    run_frame(4'hA, 1, "s2");
`ifdef ARQ_STATS_EN
    chk("s2/stat_retx", int'(stat_retx) - r0, 2);
`endif

    // Scenario 3: silence on every attempt -> four sends then drop.
    for (int a = 0; a <= MR; a++) set_plan(a, K_NONE, 0, 0, 0);
    run_frame(4'h3, 1, "s3");

    // Scenario 4: stale response then timeout, then ACK.
    set_plan(0, K_NONE, 0, 0, 1);
    set_plan(1, K_ACK, 5, 0, 0);
    run_frame(4'hC, 1, "s4");

    // Scenario 5: ACK on the timeout cycle, with a 5-cycle link stall.
    set_plan(0, K_ACK, TO, 5, 0);
    run_frame(4'h9, 1, "s5");

    // Enable low: nothing is fetched.
    enable = 1'b0;
    pops0 = pops;
    push(4'h7);
    for (int i = 0; i < 3; i++) step();
    chk("enable_off/idle", {busy, tx_valid}, 2'b00);
    chk("enable_off/no_pop", pops - pops0, 0);
    enable = 1'b1;
    set_plan(0, K_ACK, 1, 0, 0);
    run_frame(4'h7, 0, "enable_on");

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      for (int a = 0; a <= MR; a++) begin
        int r;
        r = $urandom_range(0, 9);
        set_plan(a, (r < 4) ? K_ACK : (r < 7) ? K_NACK : K_NONE,
                 $urandom_range(1, TO), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      run_frame(DW'($urandom_range(0, 15)), 1, "rand");
    end

    // Reset during WAIT_ACK with seq forced to 1 and a retry outstanding.
    if (model_seq == 1'b0) begin
      set_plan(0, K_ACK, 1, 0, 0);
      run_frame(4'h1, 1, "pre_rst");
    end
    push(4'hE);
    step();
    rx_ack_valid = 1'b0;
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    rx_ack_valid = 1'b1; rx_ack_nack = ARQ_NACK; rx_ack_seq = model_seq;
    step();
    rx_ack_valid = 1'b0;
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    step();
    chk("pre_rst/wait", {busy, tx_valid, tx_seq, retry_cnt}, 5'b10101);
    rst_n = 1'b0;
    step();
    chk("mid_rst", {busy, tx_valid, tx_seq, retry_cnt, frame_done, frame_drop}, 7'h00);
    rst_n = 1'b1;
    model_seq = 1'b0;
    step();
    chk("post_rst/idle", {busy, tx_valid}, 2'b00);
    set_plan(0, K_ACK, 2, 0, 0);
    run_frame(4'h4, 1, "post_rst");

    chk("pop_on_empty", pop_empty, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
